// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detectors: width math and the
// elaboration-time prefix-matching functions that build the next-state ROM.
package seq_detect_pkg;

  localparam int MAX_N = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  // A result of n means the whole pattern just completed.
  function automatic int next_match(input int k, input logic b,
                                    input logic [MAX_N-1:0] pat, input int n);
    int   res;
    bit   ok;
    logic sb;
    res = 0;
    for (int l = 1; l <= k + 1; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        sb = ((k + 1 - l + i) == k) ? b : pat[n - 1 - (k + 1 - l + i)];
        if (sb != pat[n - 1 - i]) ok = 1'b0;
      end
      if (ok) res = l;
    end
    return res;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int fail_len(input logic [MAX_N-1:0] pat, input int n);
    int res;
    bit ok;
    res = 0;
    for (int l = 1; l < n; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pat[n - 1 - i] != pat[l - 1 - i]) ok = 1'b0;
      end
      if (ok) res = l;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter: counts inc pulses, never wraps, clears synchronously.
module seq_hit_counter #(
  parameter int CW = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] hits,
  output logic          hit_sat
);

  logic [CW-1:0] hits_q;
  logic [CW-1:0] hits_d;
  logic          sat;

  assign sat = &hits_q;

  always_comb begin
    hits_d = hits_q;
    if (clr) begin
      hits_d = '0;
    end else if (inc && !sat) begin
      hits_d = hits_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign hits    = hits_q;
  assign hit_sat = sat;

endmodule

// File: rtl/seq_detect_mealy.sv
// Parametrised Mealy pattern detector: z fires in the same cycle as the final
// pattern bit; transitions come from a ROM folded out of the pattern at elaboration.
module seq_detect_mealy
  import seq_detect_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 8,
  localparam int          SW      = clog2(N)
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          en,
  input  logic          clr,
  input  logic          w,
  output logic          z,
  output logic [SW-1:0] state,
  output logic [CW-1:0] hits,
  output logic          hit_sat
);

  localparam int ROM_SZ = 2 ** (SW + 1);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("seq_detect_mealy: N must be in 2..16");
  end

  function automatic int rom_entry(input int k, input logic b);
    int nm;
    if (k >= N) return 0;
    nm = next_match(k, b, MAX_N'(PATTERN), N);
    if (nm == N) return OVERLAP ? fail_len(MAX_N'(PATTERN), N) : 0;
    return nm;
  endfunction

  // Entry index is {prefix length, incoming bit}; unused rows fall back to 0.
  logic [SW-1:0] next_rom [ROM_SZ];

  for (genvar g = 0; g < ROM_SZ; g++) begin : g_rom
    assign next_rom[g] = SW'(rom_entry(g / 2, 1'(g % 2)));
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          accept;
  logic          hit;

  assign accept = en & ~clr;
  assign hit    = accept & (state_q == SW'(N - 1)) & (w == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      state_d = next_rom[{state_q, w}];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  seq_hit_counter #(
    .CW(CW)
  ) u_hit_counter (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (hit),
    .clr    (clr),
    .hits   (hits),
    .hit_sat(hit_sat)
  );

  assign z     = hit;
  assign state = state_q;

endmodule
